// File: rtl/core_boot_seq.sv
// Boot sequencer: copies the ROM data image into data memory, streams INSTR/REG/BAR/PC packets into the core, then hands memory to the core.
// Each ROM word costs a fetch cycle plus a write cycle; memory writes stall on mem_ready_i, packets never stall.
package core_boot_pkg;
  typedef enum logic [2:0] {
    OP_NULL  = 3'd0,
    OP_INSTR = 3'd1,
    OP_REG   = 3'd2,
    OP_BAR   = 3'd3,
    OP_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;
    net_op_e     op;
    logic [4:0]  rsvd;
    logic [31:0] data;
    logic [9:0]  net_addr;
  } net_packet_s;
endpackage

module core_boot_seq
  import core_boot_pkg::*;
#(
  parameter int unsigned DATA_WORDS_P  = 1024,
  parameter int unsigned INSTR_WORDS_P = 1024,
  parameter int unsigned REG_WORDS_P   = 64,
  parameter logic [9:0]  ID_P          = 10'd1,
  parameter logic [31:0] BAR_MASK_P    = 32'h2,
  parameter logic [9:0]  BAR_ADDR_P    = 10'd24,
  parameter logic [31:0] START_PC_P    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic [1:0]  rom_sel_o,
  output logic [9:0]  rom_addr_o,
  input  logic [39:0] rom_data_i,
  output logic        mem_valid_o,
  output logic        mem_wen_o,
  output logic        mem_byte_not_word_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  output net_packet_s net_packet_o,
  output logic        select_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DMEM, S_INSTR, S_REG, S_BAR, S_PC, S_DONE
  } state_e;

  localparam logic PH_F = 1'b0;
  localparam logic PH_W = 1'b1;

  localparam logic [10:0] D_LAST = 11'(DATA_WORDS_P - 1);
  localparam logic [10:0] I_LAST = 11'(INSTR_WORDS_P - 1);
  localparam logic [10:0] R_LAST = 11'(REG_WORDS_P - 1);

  state_e      state_r, state_n;
  logic        ph_r, ph_n;
  logic [10:0] cnt_r, cnt_n;
  logic        w_first_r, w_first_n;
  logic [31:0] wdata_r, wdata_n;
  logic [1:0]  sel_r, sel_n;
  logic [9:0]  addr_r, addr_n;
  logic [1:0]  phase_sel;
  logic        fetch;
  logic [31:0] wdata_w;

  // image bits [39:38] carry no meaning for any packet or memory word
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data_i[39:38];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      ph_r      <= PH_F;
      cnt_r     <= '0;
      w_first_r <= 1'b0;
      wdata_r   <= '0;
      sel_r     <= '0;
      addr_r    <= '0;
    end else begin
      state_r   <= state_n;
      ph_r      <= ph_n;
      cnt_r     <= cnt_n;
      w_first_r <= w_first_n;
      wdata_r   <= wdata_n;
      sel_r     <= sel_n;
      addr_r    <= addr_n;
    end
  end

  always_comb begin
    phase_sel = 2'd0;
    case (state_r)
      S_INSTR: phase_sel = 2'd1;
      S_REG:   phase_sel = 2'd2;
      default: phase_sel = 2'd0;
    endcase
    fetch = (state_r == S_DMEM || state_r == S_INSTR || state_r == S_REG) && (ph_r == PH_F);
  end

  always_comb begin
    state_n             = state_r;
    ph_n                = ph_r;
    cnt_n               = cnt_r;
    w_first_n           = 1'b0;
    wdata_n             = wdata_r;
    sel_n               = sel_r;
    addr_n              = addr_r;
    wdata_w             = w_first_r ? rom_data_i[31:0] : wdata_r;
    rom_sel_o           = sel_r;
    rom_addr_o          = addr_r;
    mem_valid_o         = 1'b0;
    mem_wen_o           = 1'b0;
    mem_byte_not_word_o = 1'b0;
    mem_addr_o          = '0;
    mem_wdata_o         = '0;
    net_packet_o        = '0;
    select_o            = 1'b0;
    busy_o              = 1'b0;
    done_o              = 1'b0;

    // ROM address registers only move in fetch cycles so the port never toggles needlessly
    if (fetch) begin
      rom_sel_o  = phase_sel;
      rom_addr_o = cnt_r[9:0];
      sel_n      = phase_sel;
      addr_n     = cnt_r[9:0];
      ph_n       = PH_W;
      w_first_n  = 1'b1;
    end

    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_DMEM;
          ph_n    = PH_F;
          cnt_n   = '0;
        end
      end
      S_DMEM: begin
        busy_o = 1'b1;
        if (ph_r == PH_W) begin
          mem_valid_o = 1'b1;
          mem_wen_o   = 1'b1;
          mem_addr_o  = {19'b0, cnt_r, 2'b00};
          mem_wdata_o = wdata_w;
          wdata_n     = wdata_w;
          if (mem_ready_i) begin
            ph_n = PH_F;
            if (cnt_r == D_LAST) begin
              state_n = S_INSTR;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_r + 11'd1;
            end
          end
        end
      end
      S_INSTR: begin
        busy_o = 1'b1;
        if (ph_r == PH_W) begin
          net_packet_o = '{id: ID_P, op: OP_INSTR, rsvd: 5'b0,
                           data: {16'b0, rom_data_i[15:0]}, net_addr: cnt_r[9:0]};
          ph_n = PH_F;
          if (cnt_r == I_LAST) begin
            state_n = S_REG;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + 11'd1;
          end
        end
      end
      S_REG: begin
        busy_o = 1'b1;
        if (ph_r == PH_W) begin
          net_packet_o = '{id: ID_P, op: OP_REG, rsvd: 5'b0,
                           data: rom_data_i[31:0], net_addr: {4'b0, rom_data_i[37:32]}};
          ph_n = PH_F;
          if (cnt_r == R_LAST) begin
            state_n = S_BAR;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + 11'd1;
          end
        end
      end
      S_BAR: begin
        busy_o       = 1'b1;
        net_packet_o = '{id: ID_P, op: OP_BAR, rsvd: 5'b0, data: BAR_MASK_P, net_addr: BAR_ADDR_P};
        state_n      = S_PC;
        ph_n         = PH_F;
        cnt_n        = '0;
      end
      S_PC: begin
        busy_o       = 1'b1;
        net_packet_o = '{id: ID_P, op: OP_PC, rsvd: 5'b0, data: START_PC_P, net_addr: 10'd0};
        state_n      = S_DONE;
        ph_n         = PH_F;
        cnt_n        = '0;
      end
      S_DONE: begin
        select_o = 1'b1;
        done_o   = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/core_boot_seq.md
# core_boot_seq

Hardware boot sequencer for one vanilla core tile. It replaces the bench-driven bring-up with synthesizable logic that streams a boot image from a read-only image store into the data memory, then into the core over the network packet port (INSTR, REG, BAR, PC packets). It finally hands the shared data-memory port to the core. It sits between the boot image ROM, the data memory, and the core's `net_packet_flat_i`, and owns the core/loader memory-port select.

## Interface

**Parameters** (name, default, meaning):
- `DATA_WORDS_P`, 1024: data-memory words to preload; legal range 1..1024.
- `INSTR_WORDS_P`, 1024: instruction packets to send; legal range 1..1024.
- `REG_WORDS_P`, 64: register packets to send; legal range 1..64.
- `ID_P`, 10'd1: packet ID field for all generated packets.
- `BAR_MASK_P`, 32'h2: barrier mask data.
- `BAR_ADDR_P`, 10'd24: barrier packet `net_addr`.
- `START_PC_P`, 32'h0: PC packet data.

**Ports** (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `start_i`, in, 1: begin boot; sampled only in IDLE.
- `rom_sel_o`, out, 2: image region (0 data, 1 instr, 2 reg).
- `rom_addr_o`, out, 10: word index within the region.
- `rom_data_i`, in, 40: image word, valid the cycle after `rom_sel_o`/`rom_addr_o`.
- `mem_valid_o`, out, 1: loader write request.
- `mem_wen_o`, out, 1: always 1 when `mem_valid_o` is high.
- `mem_byte_not_word_o`, out, 1: constant 0.
- `mem_addr_o`, out, 32: byte address.
- `mem_wdata_o`, out, 32: write data.
- `mem_ready_i`, in, 1: memory accepts the write this cycle.
- `net_packet_o`, out, `$bits(net_packet_s)`: packet toward the core (registered into core input by the tile).
- `select_o`, out, 1: 0 = loader owns data memory, 1 = core owns it.
- `busy_o`, out, 1: any state other than IDLE or DONE.
- `done_o`, out, 1: boot complete.

## Operation

- **States:** IDLE, DMEM, INSTR, REG, BAR, PC, DONE.
- **Word counter `cnt_r`:** 11 bits, cleared on every phase entry.
- **Sub-phase bit `ph_r`:** alternates F and W within DMEM, INSTR and REG.
- **IDLE:**
  - Outputs quiescent.
  - `start_i`=1 moves to DMEM, with `ph_r`=F and `cnt_r`=0.
- **F cycle:** drive `rom_sel_o` for the phase and `rom_addr_o`=`cnt_r[9:0]`; `net_packet_o` op is NULL; `mem_valid_o`=0.
- **DMEM W:**
  - Drive `mem_valid_o`=1, `mem_addr_o`=`cnt_r`*4, and `mem_wdata_o`=`rom_data_i[31:0]`, captured into a holding register at W entry.
  - Hold the request until `mem_ready_i`=1.
  - On acceptance: if `cnt_r`==`DATA_WORDS_P`-1, go to INSTR; otherwise increment `cnt_r` and return to F.
- **INSTR W:** one cycle with packet = {ID_P, INSTR, 5'b0, {16'b0, `rom_data_i[15:0]`}, `cnt_r[9:0]`}; then advance as in DMEM, using `INSTR_WORDS_P`, into REG.
- **REG W:** one cycle with packet = {ID_P, REG, 5'b0, `rom_data_i[31:0]`, {4'b0, `rom_data_i[37:32]`}}; after the last word, go to BAR.
- **BAR:** one cycle with packet = {ID_P, BAR, 5'b0, BAR_MASK_P, BAR_ADDR_P}; then PC.
- **PC:** one cycle with packet = {ID_P, PC, 5'b0, START_PC_P, 10'd0}; then DONE.
- **DONE:**
  - `select_o`=1, `done_o`=1, packet op NULL.
  - Stays in DONE until reset; `start_i` is ignored.
- **`start_i` outside IDLE:** ignored.
- **`rom_sel_o`/`rom_addr_o` in non-F cycles:** hold their last values, so there are no spurious toggles.

## Timing

- **Reset values** (sync, `reset`=0 at a posedge): state IDLE, `cnt_r`=0, `mem_valid_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `select_o`=0, `busy_o`=0, `done_o`=0, `net_packet_o`=all-zero with op NULL, `rom_sel_o`=0, `rom_addr_o`=0.
- **Reset mid-boot:** abort immediately to reset values, including from DONE, which returns memory ownership to the loader. A partially written memory or partially loaded core is not repaired; the next boot rewrites everything.
- **ROM latency:** exactly 1 cycle; `rom_data_i` is sampled only in W cycles.
- **Memory handshake:** `mem_valid_o`, `mem_addr_o` and `mem_wdata_o` stay stable while `mem_ready_i`=0. Transfer happens on a cycle where both are 1. No new request is issued in the cycle after acceptance, because that cycle is F.
- **Packets:** exactly one non-NULL packet per W/BAR/PC cycle, with no back-pressure.
- **Latency with `mem_ready_i` tied 1:** `start_i` is accepted at edge 0. `done_o` rises after edge 2(D+I+R)+2, where D, I and R are the three word-count parameters. `busy_o` is high for exactly 2(D+I+R)+2 cycles.
- **`select_o`:** is 0 throughout DMEM..PC, and `mem_valid_o` is 0 for at least 2I+2R+2 cycles before `select_o` rises, so there is no overlap of core and loader writes.
- **`cnt_r` wrap:** never occurs; compares use the full 11 bits against (N-1).

## Test plan

- **Basic boot:** D=4, I=3, R=2, ready=1, image data words 0xA0..0xA3. Required response:
  - memory writes at addresses 0,4,8,12 with data A0..A3;
  - then 3 INSTR packets with `net_addr` 0..2;
  - 2 REG packets whose `net_addr` equals image bits [37:32];
  - BAR (data 0x2, addr 24), then PC (data 0, addr 0);
  - `done_o` after edge 20.
- **Back-pressure:** `mem_ready_i` low for 5 cycles on word 1. Request is held stable for 5 cycles, addr 4 is written once, and total latency grows by exactly 5.
- **Start ignored:** pulse `start_i` during REG and during DONE. No restart, no duplicate packets.
- **Reset mid-DMEM:** assert reset after word 2 is accepted. Next cycle all outputs are at reset values; a new `start_i` rewrites from address 0.
- **Reset in DONE:** `select_o` and `done_o` drop to 0 on the next cycle; a reboot completes with the same packet sequence as the basic boot.
- **Maximum sizes:** D=1024, I=1024, R=64. The last data write is at address 0xFFC, the last INSTR `net_addr` is 1023, and `done_o` rises after edge 4226.
